// File: rtl/pc_sequencer.sv
// Program-counter stage: next-PC selection, RUN/STALL/FLUSH sequencing, deferred $31 link write
// and the {V,N,Z} status register. Define PERF_CNT_EN to add taken_cnt/cycle_cnt counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  selectmux,
    input  logic        baln_out,
    input  logic        bneal_out,
    input  logic        jalpc,
    input  logic [31:0] branch_target,
    input  logic [31:0] mem_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] reg_target,
    input  logic [2:0]  flags_in,
    input  logic        flags_we,
    output logic [2:0]  statusregister,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] cycle_cnt
`endif
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [1:0]  resume_q, resume_d;
    logic [1:0]  eff_state;
    logic [31:0] pc_q, pc_d;
    logic [31:0] link_data_q, link_data_d;
    logic        link_pend_q, link_pend_d;
    logic [2:0]  status_q, status_d;
    logic [31:0] sel_target;
    logic        taken;
    logic        link_req;

    // While in STALL the stage behaves as the state it left once stall drops.
    assign eff_state = (state_q == ST_STALL) ? resume_q : state_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign taken     = (selectmux == 3'b001) || (selectmux == 3'b010) ||
                       (selectmux == 3'b011) || (selectmux == 3'b100);
    assign link_req  = baln_out || bneal_out || jalpc || (selectmux == 3'b100);

    always_comb begin
        case (selectmux)
            3'b001:  sel_target = {branch_target[31:2], 2'b00};
            3'b010:  sel_target = {mem_target[31:2], 2'b00};
            3'b011:  sel_target = {pc_plus4[31:28], jump_index, 2'b00};
            3'b100:  sel_target = {reg_target[31:2], 2'b00};
            default: sel_target = pc_plus4;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        resume_d    = resume_q;
        pc_d        = pc_q;
        link_pend_d = link_pend_q;
        link_data_d = link_data_q;
        status_d    = status_q;
        if (stall) begin
            state_d  = ST_STALL;
            resume_d = eff_state;
        end else begin
            link_pend_d = 1'b0;
            if (flags_we) begin
                status_d = flags_in;
            end
            if (eff_state == ST_FLUSH) begin
                pc_d    = pc_plus4;
                state_d = ST_RUN;
            end else begin
                pc_d    = sel_target;
                state_d = taken ? ST_FLUSH : ST_RUN;
                if (link_req) begin
                    link_pend_d = 1'b1;
                    link_data_d = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all of them update together.
        if (reset) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            pc_q        <= RESET_PC;
            link_pend_q <= 1'b0;
            link_data_q <= 32'd0;
            status_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            pc_q        <= pc_d;
            link_pend_q <= link_pend_d;
            link_data_q <= link_data_d;
            status_q    <= status_d;
        end
    end

    assign pc             = pc_q;
    assign statusregister = status_q;
    assign flush          = (eff_state == ST_FLUSH) && !stall;
    assign link_we        = link_pend_q && !stall;
    assign link_addr      = LINK_REG;
    assign link_data      = link_data_q;

`ifdef PERF_CNT_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (!stall && (eff_state == ST_RUN) && taken) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
        cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model checked every cycle plus
// hand-computed directed expectations.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [2:0]  selectmux;
    logic        baln_out, bneal_out, jalpc;
    logic [31:0] branch_target, mem_target, reg_target;
    logic [25:0] jump_index;
    logic [2:0]  flags_in;
    logic        flags_we;
    logic [2:0]  statusregister;
    logic [31:0] pc, pc_plus4, link_data;
    logic        flush, link_we;
    logic [4:0]  link_addr;
`ifdef PERF_CNT_EN
    logic [31:0] taken_cnt, cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC), .LINK_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .stall(stall), .selectmux(selectmux),
        .baln_out(baln_out), .bneal_out(bneal_out), .jalpc(jalpc),
        .branch_target(branch_target), .mem_target(mem_target),
        .jump_index(jump_index), .reg_target(reg_target),
        .flags_in(flags_in), .flags_we(flags_we),
        .statusregister(statusregister), .pc(pc), .pc_plus4(pc_plus4),
        .flush(flush), .link_we(link_we), .link_addr(link_addr), .link_data(link_data)
`ifdef PERF_CNT_EN
        , .taken_cnt(taken_cnt), .cycle_cnt(cycle_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a flush is "owed" after an accepted transfer, a link is "owed"
    // after an accepted linking instruction; both are paid out on the next unstalled cycle.
    bit          m_valid = 1'b0;
    logic [31:0] m_pc, m_link_data, m_taken, m_cycles;
    logic        m_flush_owed, m_link_owed;
    logic [2:0]  m_status;

    function automatic logic [31:0] model_target(input logic [31:0] cur);
        logic [31:0] seq;
        seq = cur + 32'd4;
        case (selectmux)
            3'd1:    return branch_target & ~32'h3;
            3'd2:    return mem_target & ~32'h3;
            3'd3:    return {seq[31:28], jump_index, 2'b00};
            3'd4:    return reg_target & ~32'h3;
            default: return seq;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid      <= 1'b1;
            m_pc         <= RST_PC;
            m_flush_owed <= 1'b0;
            m_link_owed  <= 1'b0;
            m_link_data  <= 32'd0;
            m_status     <= 3'd0;
            m_taken      <= 32'd0;
            m_cycles     <= 32'd0;
        end else if (m_valid) begin
            m_cycles <= m_cycles + 32'd1;
            if (!stall) begin
                if (flags_we) m_status <= flags_in;
                m_link_owed <= 1'b0;
                if (m_flush_owed) begin
                    m_pc         <= m_pc + 32'd4;
                    m_flush_owed <= 1'b0;
                end else begin
                    m_pc         <= model_target(m_pc);
                    m_flush_owed <= (selectmux >= 3'd1) && (selectmux <= 3'd4);
                    if ((selectmux >= 3'd1) && (selectmux <= 3'd4)) m_taken <= m_taken + 32'd1;
                    if (baln_out || bneal_out || jalpc || selectmux == 3'd4) begin
                        m_link_owed <= 1'b1;
                        m_link_data <= m_pc + 32'd4;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_pc", pc, m_pc);
            check("m_pc_plus4", pc_plus4, m_pc + 32'd4);
            check("m_flush", 32'(flush), 32'(m_flush_owed && !stall && !reset));
            check("m_link_we", 32'(link_we), 32'(m_link_owed && !stall && !reset));
            check("m_link_addr", 32'(link_addr), 32'd31);
            check("m_link_data", link_data, m_link_data);
            check("m_status", 32'(statusregister), 32'(m_status));
`ifdef PERF_CNT_EN
            check("m_taken_cnt", taken_cnt, m_taken);
            check("m_cycle_cnt", cycle_cnt, m_cycles);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Branch to addr-4; the flush cycle that follows lands the PC on addr in RUN.
    task automatic goto(input logic [31:0] addr);
        selectmux = 3'd1;
        branch_target = addr - 32'd4;
        step();
        selectmux = 3'd0;
        step();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; selectmux = 3'd0;
        baln_out = 1'b0; bneal_out = 1'b0; jalpc = 1'b0;
        branch_target = 32'd0; mem_target = 32'd0; reg_target = 32'd0;
        jump_index = 26'd0; flags_in = 3'd0; flags_we = 1'b0;
        step(); step();
        reset = 1'b0; #1;
        check("reset_pc", pc, 32'h0040_0000);
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_link_we", 32'(link_we), 32'd0);
        check("reset_status", 32'(statusregister), 32'd0);
        check("reset_link_data", link_data, 32'd0);

        // Sequential fetch, including unused select codes.
        goto(32'h100); #1;
        check("seq_start", pc, 32'h100);
        step(); check("seq_1", pc, 32'h104); check("seq_1_flush", 32'(flush), 32'd0);
        step(); check("seq_2", pc, 32'h108);
        step(); check("seq_3", pc, 32'h10C); check("seq_3_flush", 32'(flush), 32'd0);
        selectmux = 3'd5; step(); check("sel101", pc, 32'h110);
        selectmux = 3'd7; step(); check("sel111", pc, 32'h114);
        check("sel111_flush", 32'(flush), 32'd0);
        selectmux = 3'd0;

        // Branch with misaligned target; flush slot ignores selectmux.
        goto(32'h200);
        selectmux = 3'd1; branch_target = 32'h303; #1;
        check("br_pre_flush", 32'(flush), 32'd0);
        step();
        selectmux = 3'd1; branch_target = 32'h888; #1;
        check("br_pc", pc, 32'h300);
        check("br_flush", 32'(flush), 32'd1);
        step();
        selectmux = 3'd0; #1;
        check("br_slot_pc", pc, 32'h304);
        check("br_flush_once", 32'(flush), 32'd0);

        // Register jump links.
        goto(32'h1000_0040);
        selectmux = 3'd4; reg_target = 32'h500; step();
        selectmux = 3'd0; #1;
        check("jr_pc", pc, 32'h500);
        check("jr_link_we", 32'(link_we), 32'd1);
        check("jr_link_addr", 32'(link_addr), 32'd31);
        check("jr_link_data", link_data, 32'h1000_0044);
        step();
        check("jr_link_once", 32'(link_we), 32'd0);
        check("jr_after", pc, 32'h504);

        // Pseudo-direct jump, then stall across the flush.
        goto(32'h4000_0000);
        selectmux = 3'd3; jump_index = 26'h0000010; step();
        selectmux = 3'd0; stall = 1'b1; #1;
        check("j_pc", pc, 32'h4000_0040);
        check("j_stall_flush0", 32'(flush), 32'd0);
        step(); check("j_stall1", pc, 32'h4000_0040);
        step(); check("j_stall2", pc, 32'h4000_0040);
        step(); check("j_stall3", pc, 32'h4000_0040);
        stall = 1'b0; #1;
        check("j_release_flush", 32'(flush), 32'd1);
        step();
        check("j_after_flush", pc, 32'h4000_0044);
        check("j_flush_done", 32'(flush), 32'd0);

        // Jump region comes from pc+4, which crosses into the next 256 MB region here.
        goto(32'h4FFF_FFFC);
        selectmux = 3'd3; jump_index = 26'h3FF_FFFF; jalpc = 1'b1; step();
        selectmux = 3'd0; jalpc = 1'b0; #1;
        check("j_region", pc, 32'h5FFF_FFFC);
        check("jalpc_data", link_data, 32'h5000_0000);
        step();

        // Branch-and-link with a stall in the link cycle.
        goto(32'h800);
        selectmux = 3'd1; branch_target = 32'h900; baln_out = 1'b1; step();
        baln_out = 1'b0; selectmux = 3'd0; stall = 1'b1; #1;
        check("bal_stall_we", 32'(link_we), 32'd0);
        step();
        stall = 1'b0; #1;
        check("bal_release_we", 32'(link_we), 32'd1);
        check("bal_release_data", link_data, 32'h804);
        check("bal_release_flush", 32'(flush), 32'd1);
        step();
        check("bal_after", pc, 32'h904);
        bneal_out = 1'b1; step(); bneal_out = 1'b0; #1;
        check("bneal_data", link_data, 32'h908);

        // Flags: held under stall, then latched.
        flags_we = 1'b1; flags_in = 3'b110; stall = 1'b1; step();
        check("flags_stalled", 32'(statusregister), 32'd0);
        stall = 1'b0; step();
        check("flags_latched", 32'(statusregister), 32'b110);
        selectmux = 3'd2; mem_target = 32'hA02; flags_in = 3'b001; step();
        flags_we = 1'b0; selectmux = 3'd0; #1;
        check("both_pc", pc, 32'hA00);
        check("both_status", 32'(statusregister), 32'b001);
        step();

        // PC wraps modulo 2^32.
        goto(32'hFFFF_FFFC); #1;
        check("wrap_plus4", pc_plus4, 32'h0);
        step();
        check("wrap_pc", pc, 32'h0);

        // Reset wins over stall and a pending link.
        selectmux = 3'd4; reg_target = 32'h700; flags_we = 1'b1; flags_in = 3'b111; step();
        flags_we = 1'b0; stall = 1'b1; reset = 1'b1; step();
        reset = 1'b0; stall = 1'b0; selectmux = 3'd0; #1;
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_link_we", 32'(link_we), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_status", 32'(statusregister), 32'd0);

        // Four taken transfers.
        for (int i = 0; i < 4; i++) begin
            selectmux = 3'd1; branch_target = 32'h2000 + 32'(i) * 32'h40; step();
            selectmux = 3'd0; step();
        end
`ifdef PERF_CNT_EN
        check("taken_cnt_4", taken_cnt, 32'd4);
`endif
        check("after_4_taken", pc, 32'h20C4);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
